chunk_add_sub: RTL

CHUNK_ADD_SUB -- requirements
Module: chunk_add_sub

---
 rtl/chunk_add_sub_pkg.sv | 13 +
 rtl/add_sub_chunk.sv | 29 ++
 rtl/chunk_add_sub.sv | 118 +++++++++++
 3 files changed

// File: rtl/chunk_add_sub_pkg.sv
// Shared types for chunk_add_sub: controller states and operation mode encodings.
package chunk_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can form signed overflow on the final chunk.
module add_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/chunk_add_sub.sv
// Multi-cycle add/subtract processing CHUNK bits per cycle, LSB chunk first.
// Define CHUNK_ADD_SUB_SATURATE_EN to clamp the sum to signed max/min on overflow.
//
// state   | meaning
// ST_IDLE | waiting for an operation, in_ready high
// ST_RUN  | one chunk per cycle, carry held in r_cin between chunks
// ST_DONE | result presented with out_valid until out_ready
module chunk_add_sub
  import chunk_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunk_add_sub: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic             r_cin, r_carry, r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic [CHUNK-1:0] w_chunk_a, w_chunk_b, w_chunk_sum;
  logic             w_cout, w_cmsb, w_ovf, w_accept;
  logic [WIDTH-1:0] w_acc_nxt, w_sum_final;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_chunk_a = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_chunk_b = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_ovf     = w_cout ^ w_cmsb;

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (w_chunk_a),
    .i_b    (w_chunk_b),
    .i_cin  (r_cin),
    .o_sum  (w_chunk_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)            w_state_nxt = ST_RUN;
      ST_RUN:  if (r_idx == LAST_IDX)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)           w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_idx)*CHUNK +: CHUNK] = w_chunk_sum;
    w_sum_final = w_acc_nxt;
`ifdef CHUNK_ADD_SUB_SATURATE_EN
    if (w_ovf)
      w_sum_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Subtraction is A + ~B + 1: invert B and seed the carry at capture time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cin   <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b ^ {WIDTH{mode == MODE_SUB}};
      r_cin <= (mode == MODE_SUB);
      r_idx <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= w_acc_nxt;
      r_cin <= w_cout;
      r_idx <= r_idx + IDX_W'(1);
      if (r_idx == LAST_IDX) begin
        r_sum   <= w_sum_final;
        r_carry <= w_cout;
        r_ovf   <= w_ovf;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule
